bram_read_arbiter: RTL and testbench
====================================

// Module: bram_read_arbiter
// PURPOSE
// - Shares the BRAM_COUNT LUT banks among NUM_REQ address-calc requesters.
// - Each requester issues (bank, addr) reads. Each bank serves at most one read per cycle.
// - Bank conflicts are serialised; read data is returned to the owning requester.
// - Sits between the Address_calc instances and the Bram instances in the matrix datapath, so LUTS_PER_CLOCK > 1 can share banks.
// PARAMETERS
// - NUM_REQ          2   number of requesters (LUTS_PER_CLOCK)
// - BRAM_COUNT       2   number of BRAM banks
// - BRAM_COUNT_SIZE  1   width of a bank index
// - ADDR_SIZE        4   BRAM address width
// - RAM_WIDTH        8   BRAM data width
// - CNT_SIZE        16   width of the conflict counter
// PORTS
// - clock           in   1                     single clock, rising edge
// - reset           in   1                     asynchronous, active-high
// - req_valid       in   NUM_REQ               per-requester read request
// - req_bank        in   NUM_REQ*BRAM_COUNT_SIZE  bank index, requester r at [r*BRAM_COUNT_SIZE +: BRAM_COUNT_SIZE]
// - req_addr        in   NUM_REQ*ADDR_SIZE     address, requester r at [r*ADDR_SIZE +: ADDR_SIZE]
// - req_ready       out  NUM_REQ               grant; request accepted on an edge where valid&ready
// - bram_en         out  BRAM_COUNT            bank enable (combinational)
// - bram_addr       out  BRAM_COUNT*ADDR_SIZE  bank address (combinational)
// - bram_data       in   BRAM_COUNT*RAM_WIDTH  bank read data, 1 cycle after the address edge
// - rsp_valid       out  NUM_REQ               1-cycle pulse, read data returned
// - rsp_data        out  NUM_REQ*RAM_WIDTH     read data per requester
// - conflict_count  out  CNT_SIZE              cycles with at least one stalled request
// - busy            out  1                     any read in flight
// BEHAVIOUR
// - Grant logic (combinational)
//   - Per bank b, the candidates are requesters with req_valid=1 and req_bank=b.
//   - At most one candidate is granted; the grant drives req_ready[r]=1.
//   - A granted request drives bram_en[b]=1 and bram_addr[b]=req_addr[r] in the same cycle.
//   - Ungrant banks: bram_en[b]=0 and bram_addr[b] holds its last granted value (registered copy).
// - Out-of-range bank (req_bank >= BRAM_COUNT)
//   - req_ready=1 immediately; no BRAM access.
//   - Returns rsp_data=0 with normal latency.
// - Pipeline (two registered stages)
//   - Accept edge t: p_valid[r]<=1, p_bank[r]<=req_bank.
//   - Edge t+1: rsp_valid[r]<=p_valid[r]; rsp_data[r]<=bram_data[p_bank[r]], or 0 if out of range.
//   - Latency: accept edge -> rsp_valid high for exactly one cycle after the next edge.
//   - Throughput: 1 read/requester/cycle with no conflicts. Responses cannot be back-pressured.
// - Stability: an ungranted requester must hold req_bank and req_addr stable; dropping req_valid withdraws the request (legal).
// - Multiple requesters may target different banks in the same cycle; all are granted.
// - conflict_count
//   - Increments by 1 on each edge where any req_valid is high with req_ready low.
//   - Saturates at all-ones; no wrap.
// - busy = |p_valid.
// - Reset (asynchronous, any time)
//   - All of the following go to 0: rsp_valid, rsp_data, p_valid, p_bank, registered bram_addr copies, conflict_count, round-robin pointers.
//   - In-flight reads are discarded, with no rsp_valid after reset.
//   - The comb outputs req_ready and bram_en also read 0 while reset is high.
// CONFIGURATION
// - ARB_ROUND_ROBIN_EN defined
//   - Per-bank pointer rr_ptr[b] (reset 0).
//   - Winner is the first candidate at index >= rr_ptr[b], wrapping modulo NUM_REQ.
//   - After a grant on bank b, rr_ptr[b] <= winner+1 mod NUM_REQ.
//   - Pointer is unchanged when bank b has no grant.
// - ARB_ROUND_ROBIN_EN undefined: fixed priority, lowest requester index wins; no pointer registers.
// TESTING
// 1. No conflict
//    - Stimulus: req0 bank0 addr3, req1 bank1 addr5, one cycle; Bram bank0[3]=0x11, bank1[5]=0x22.
//    - Response: both ready same cycle; rsp_valid=2'b11 one cycle after the next edge; rsp_data0=0x11, rsp_data1=0x22; conflict_count=0.
// 2. Conflict, fixed priority
//    - Stimulus: req0 and req1 both bank0, addrs 1 and 2, held valid.
//    - Response: req0 granted cycle 0, req1 cycle 1; rsp order 0 then 1; conflict_count=1.
// 3. Round robin (ARB_ROUND_ROBIN_EN)
//    - Stimulus: both requesters hold bank0 valid for 4 cycles.
//    - Response: grants alternate 0,1,0,1; conflict_count=4.
// 4. Out-of-range bank
//    - Stimulus: BRAM_COUNT=2, BRAM_COUNT_SIZE=2, req_bank=3.
//    - Response: ready immediately, bram_en=0, rsp_data=0 at normal latency.
// 5. Reset mid-read
//    - Stimulus: reset asserted asynchronously between accept and response.
//    - Response: rsp_valid stays 0, busy=0, conflict_count=0, pointers 0.
// 6. Saturation
//    - Stimulus: CNT_SIZE=2, 5 stalled cycles.
//    - Response: conflict_count=3, held.

Source files
------------

// File: rtl/bram_read_arbiter_if.sv
// Request, BRAM and response bundle between the address-calc requesters,
// the shared BRAM banks and bram_read_arbiter.
interface bram_read_arbiter_if #(
    parameter int NUM_REQ         = 2,
    parameter int BRAM_COUNT      = 2,
    parameter int BRAM_COUNT_SIZE = 1,
    parameter int ADDR_SIZE       = 4,
    parameter int RAM_WIDTH       = 8,
    parameter int CNT_SIZE        = 16
);
    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ*BRAM_COUNT_SIZE-1:0] req_bank;
    logic [NUM_REQ*ADDR_SIZE-1:0]       req_addr;
    logic [NUM_REQ-1:0]                 req_ready;
    logic [BRAM_COUNT-1:0]              bram_en;
    logic [BRAM_COUNT*ADDR_SIZE-1:0]    bram_addr;
    logic [BRAM_COUNT*RAM_WIDTH-1:0]    bram_data;
    logic [NUM_REQ-1:0]                 rsp_valid;
    logic [NUM_REQ*RAM_WIDTH-1:0]       rsp_data;
    logic [CNT_SIZE-1:0]                conflict_count;
    logic                               busy;

    modport slave (
        input  req_valid, req_bank, req_addr, bram_data,
        output req_ready, bram_en, bram_addr, rsp_valid, rsp_data, conflict_count, busy
    );

    modport master (
        output req_valid, req_bank, req_addr, bram_data,
        input  req_ready, bram_en, bram_addr, rsp_valid, rsp_data, conflict_count, busy
    );
endinterface

// File: rtl/bram_read_arbiter.sv
// Shares BRAM banks among several read requesters, serialising bank conflicts.
// Define ARB_ROUND_ROBIN_EN for per-bank round robin; default is fixed priority.
module bram_read_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int BRAM_COUNT      = 2,
    parameter int BRAM_COUNT_SIZE = 1,
    parameter int ADDR_SIZE       = 4,
    parameter int RAM_WIDTH       = 8,
    parameter int CNT_SIZE        = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    bram_read_arbiter_if.slave   bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [BRAM_COUNT-1:0][NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0]                 oor;
    logic [NUM_REQ-1:0]                 ready;
    logic [NUM_REQ-1:0]                 p_valid_reg;
    logic [BRAM_COUNT_SIZE-1:0]         p_bank_reg [NUM_REQ];
    logic [NUM_REQ-1:0]                 rsp_valid_reg;
    logic [NUM_REQ*RAM_WIDTH-1:0]       rsp_data_reg;
    logic [CNT_SIZE-1:0]                conflict_reg;

    for (genvar gi = 0; gi < BRAM_COUNT; gi++) begin : g_bank
        logic [NUM_REQ-1:0]   cand;
        logic [NUM_REQ-1:0]   win_onehot;
        logic [ADDR_SIZE-1:0] win_addr;
        logic [ADDR_SIZE-1:0] addr_reg;

        always_comb begin
            cand = '0;
            for (int r = 0; r < NUM_REQ; r++) begin
                cand[r] = !reset && bus.req_valid[r] &&
                          (bus.req_bank[r*BRAM_COUNT_SIZE +: BRAM_COUNT_SIZE] == BRAM_COUNT_SIZE'(gi));
            end
        end

`ifdef ARB_ROUND_ROBIN_EN
        logic [PTR_W-1:0] rr_ptr_reg;
        logic [PTR_W-1:0] rr_ptr_next;

        // Search starts at the pointer and wraps, so the last winner goes to the back.
        always_comb begin
            int idx;
            idx         = 0;
            win_onehot  = '0;
            rr_ptr_next = rr_ptr_reg;
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (int'(rr_ptr_reg) + k) % NUM_REQ;
                if (win_onehot == '0 && cand[idx]) begin
                    win_onehot[idx] = 1'b1;
                    rr_ptr_next     = PTR_W'((idx + 1) % NUM_REQ);
                end
            end
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset)
                rr_ptr_reg <= '0;
            else if (|win_onehot)
                rr_ptr_reg <= rr_ptr_next;
        end
`else
        always_comb begin
            win_onehot = '0;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (win_onehot == '0 && cand[k])
                    win_onehot[k] = 1'b1;
            end
        end
`endif

        // An idle bank keeps presenting the address of its last granted read.
        always_comb begin
            win_addr = addr_reg;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (win_onehot[k])
                    win_addr = bus.req_addr[k*ADDR_SIZE +: ADDR_SIZE];
            end
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset)
                addr_reg <= '0;
            else if (|win_onehot)
                addr_reg <= win_addr;
        end

        assign grant[gi]                                  = win_onehot;
        assign bus.bram_en[gi]                            = |win_onehot;
        assign bus.bram_addr[gi*ADDR_SIZE +: ADDR_SIZE]   = win_addr;
    end

    // Requests to a nonexistent bank are accepted at once and answered with zero.
    always_comb begin
        oor   = '0;
        ready = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            oor[r] = !reset && bus.req_valid[r] &&
                     (int'(bus.req_bank[r*BRAM_COUNT_SIZE +: BRAM_COUNT_SIZE]) >= BRAM_COUNT);
            ready[r] = oor[r];
            for (int b = 0; b < BRAM_COUNT; b++)
                ready[r] = ready[r] | grant[b][r];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            p_valid_reg   <= '0;
            rsp_valid_reg <= '0;
            rsp_data_reg  <= '0;
            conflict_reg  <= '0;
            for (int r = 0; r < NUM_REQ; r++)
                p_bank_reg[r] <= '0;
        end else begin
            p_valid_reg   <= bus.req_valid & ready;
            rsp_valid_reg <= p_valid_reg;
            for (int r = 0; r < NUM_REQ; r++) begin
                if (bus.req_valid[r] && ready[r])
                    p_bank_reg[r] <= bus.req_bank[r*BRAM_COUNT_SIZE +: BRAM_COUNT_SIZE];
                if (p_valid_reg[r]) begin
                    if (int'(p_bank_reg[r]) >= BRAM_COUNT)
                        rsp_data_reg[r*RAM_WIDTH +: RAM_WIDTH] <= '0;
                    else
                        rsp_data_reg[r*RAM_WIDTH +: RAM_WIDTH] <=
                            bus.bram_data[int'(p_bank_reg[r])*RAM_WIDTH +: RAM_WIDTH];
                end
            end
            // Saturating count of cycles in which some request was held off.
            if ((|(bus.req_valid & ~ready)) && !(&conflict_reg))
                conflict_reg <= conflict_reg + CNT_SIZE'(1);
        end
    end

    assign bus.req_ready      = ready;
    assign bus.rsp_valid      = rsp_valid_reg;
    assign bus.rsp_data       = rsp_data_reg;
    assign bus.conflict_count = conflict_reg;
    assign bus.busy           = |p_valid_reg;
endmodule

// File: tb/tb_bram_read_arbiter.sv
// Directed bench for bram_read_arbiter: per-cycle vector table plus reset and
// saturation sequences. Expectations follow ARB_ROUND_ROBIN_EN when defined.
module tb_bram_read_arbiter;
    logic clock;
    logic reset;
    int   total;
    int   bad;

    bram_read_arbiter_if #(.BRAM_COUNT_SIZE(2))                bus ();
    bram_read_arbiter_if #(.BRAM_COUNT_SIZE(2), .CNT_SIZE(2))  sbus ();

    bram_read_arbiter #(.BRAM_COUNT_SIZE(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    bram_read_arbiter #(.BRAM_COUNT_SIZE(2), .CNT_SIZE(2)) dut_sat (
        .clock (clock),
        .reset (reset),
        .bus   (sbus)
    );

    assign sbus.req_valid = bus.req_valid;
    assign sbus.req_bank  = bus.req_bank;
    assign sbus.req_addr  = bus.req_addr;
    assign sbus.bram_data = bus.bram_data;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Bank b word a holds a distinct value; bank0[3]=0x11, bank1[5]=0x22.
    logic [7:0] mem0 [16];
    logic [7:0] mem1 [16];
    logic [7:0] bd0 = 8'h00;
    logic [7:0] bd1 = 8'h00;
    initial begin
        for (int a = 0; a < 16; a++) begin
            mem0[a] = 8'h0E + 8'(a);
            mem1[a] = 8'h1D + 8'(a);
        end
    end
    always @(posedge clock) begin
        if (bus.bram_en[0]) bd0 <= mem0[bus.bram_addr[3:0]];
        if (bus.bram_en[1]) bd1 <= mem1[bus.bram_addr[7:4]];
    end
    assign bus.bram_data = {bd1, bd0};

    typedef struct {
        bit         rst;
        logic [1:0] rv;
        logic [3:0] rb;
        logic [7:0] ra;
        logic [1:0] rdy;
        logic [1:0] en;
        logic [7:0] addr;
        logic [1:0] rspv;
        logic [15:0] rspd;
        logic [15:0] cnt;
        logic       busy;
    } vec_t;

    vec_t vecs [18];

    function automatic vec_t mk(bit rst, logic [1:0] rv, logic [3:0] rb, logic [7:0] ra,
                                logic [1:0] rdy, logic [1:0] en, logic [7:0] addr,
                                logic [1:0] rspv, logic [15:0] rspd, logic [15:0] cnt,
                                logic busy);
        vec_t v;
        v.rst = rst; v.rv = rv; v.rb = rb; v.ra = ra; v.rdy = rdy; v.en = en;
        v.addr = addr; v.rspv = rspv; v.rspd = rspd; v.cnt = cnt; v.busy = busy;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    task automatic drive(input logic [1:0] rv, input logic [3:0] rb, input logic [7:0] ra);
        bus.req_valid = rv;
        bus.req_bank  = rb;
        bus.req_addr  = ra;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        drive(2'b00, 4'h0, 8'h00);

        // rst rv rb ra | rdy en addr rspv rspd cnt busy
        vecs[0]  = mk(0, 2'b00, 4'b0000, 8'h00, 2'b00, 2'b00, 8'h00, 2'b00, 16'h0000, 0, 0);
        vecs[1]  = mk(0, 2'b11, 4'b0100, 8'h53, 2'b11, 2'b11, 8'h53, 2'b00, 16'h0000, 0, 0);
        vecs[2]  = mk(0, 2'b00, 4'b0000, 8'h00, 2'b00, 2'b00, 8'h53, 2'b00, 16'h0000, 0, 1);
        vecs[3]  = mk(0, 2'b00, 4'b0000, 8'h00, 2'b00, 2'b00, 8'h53, 2'b11, 16'h2211, 0, 0);
        vecs[4]  = mk(1, 2'b11, 4'b0000, 8'h21, 2'b01, 2'b01, 8'h01, 2'b00, 16'h0000, 0, 0);
        vecs[5]  = mk(0, 2'b10, 4'b0000, 8'h21, 2'b10, 2'b01, 8'h02, 2'b00, 16'h0000, 1, 1);
        vecs[6]  = mk(0, 2'b00, 4'b0000, 8'h00, 2'b00, 2'b00, 8'h02, 2'b01, 16'h000F, 1, 1);
        vecs[7]  = mk(0, 2'b00, 4'b0000, 8'h00, 2'b00, 2'b00, 8'h02, 2'b10, 16'h1000, 1, 0);
        vecs[8]  = mk(1, 2'b11, 4'b0111, 8'h57, 2'b11, 2'b10, 8'h50, 2'b00, 16'h0000, 0, 0);
        vecs[9]  = mk(0, 2'b00, 4'b0000, 8'h00, 2'b00, 2'b00, 8'h50, 2'b00, 16'h0000, 0, 1);
        vecs[10] = mk(0, 2'b00, 4'b0000, 8'h00, 2'b00, 2'b00, 8'h50, 2'b11, 16'h2200, 0, 0);
        vecs[11] = mk(1, 2'b11, 4'b0000, 8'h43, 2'b01, 2'b01, 8'h03, 2'b00, 16'h0000, 0, 0);
`ifdef ARB_ROUND_ROBIN_EN
        vecs[12] = mk(0, 2'b11, 4'b0000, 8'h43, 2'b10, 2'b01, 8'h04, 2'b00, 16'h0000, 1, 1);
        vecs[13] = mk(0, 2'b11, 4'b0000, 8'h43, 2'b01, 2'b01, 8'h03, 2'b01, 16'h0011, 2, 1);
        vecs[14] = mk(0, 2'b11, 4'b0000, 8'h43, 2'b10, 2'b01, 8'h04, 2'b10, 16'h1200, 3, 1);
        vecs[15] = mk(0, 2'b00, 4'b0000, 8'h00, 2'b00, 2'b00, 8'h04, 2'b01, 16'h0011, 4, 1);
        vecs[16] = mk(0, 2'b00, 4'b0000, 8'h00, 2'b00, 2'b00, 8'h04, 2'b10, 16'h1200, 4, 0);
        vecs[17] = mk(0, 2'b00, 4'b0000, 8'h00, 2'b00, 2'b00, 8'h04, 2'b00, 16'h0000, 4, 0);
`else
        vecs[12] = mk(0, 2'b11, 4'b0000, 8'h43, 2'b01, 2'b01, 8'h03, 2'b00, 16'h0000, 1, 1);
        vecs[13] = mk(0, 2'b11, 4'b0000, 8'h43, 2'b01, 2'b01, 8'h03, 2'b01, 16'h0011, 2, 1);
        vecs[14] = mk(0, 2'b11, 4'b0000, 8'h43, 2'b01, 2'b01, 8'h03, 2'b01, 16'h0011, 3, 1);
        vecs[15] = mk(0, 2'b00, 4'b0000, 8'h00, 2'b00, 2'b00, 8'h03, 2'b01, 16'h0011, 4, 1);
        vecs[16] = mk(0, 2'b00, 4'b0000, 8'h00, 2'b00, 2'b00, 8'h03, 2'b01, 16'h0011, 4, 0);
        vecs[17] = mk(0, 2'b00, 4'b0000, 8'h00, 2'b00, 2'b00, 8'h03, 2'b00, 16'h0000, 4, 0);
`endif

        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            if (vecs[i].rst) do_reset();
            drive(vecs[i].rv, vecs[i].rb, vecs[i].ra);
            @(negedge clock);
            $display("row %0d rv=%b ready=%b en=%b addr=%h rsp_valid=%b rsp_data=%h cnt=%0d busy=%b",
                     i, vecs[i].rv, bus.req_ready, bus.bram_en, bus.bram_addr,
                     bus.rsp_valid, bus.rsp_data, bus.conflict_count, bus.busy);
            chk($sformatf("r%0d_ready", i), 32'(bus.req_ready), 32'(vecs[i].rdy));
            chk($sformatf("r%0d_bram_en", i), 32'(bus.bram_en), 32'(vecs[i].en));
            chk($sformatf("r%0d_bram_addr", i), 32'(bus.bram_addr), 32'(vecs[i].addr));
            chk($sformatf("r%0d_rsp_valid", i), 32'(bus.rsp_valid), 32'(vecs[i].rspv));
            for (int r = 0; r < 2; r++)
                if (vecs[i].rspv[r])
                    chk($sformatf("r%0d_rsp_data%0d", i, r),
                        32'(bus.rsp_data[r*8 +: 8]), 32'(vecs[i].rspd[r*8 +: 8]));
            chk($sformatf("r%0d_conflict", i), 32'(bus.conflict_count), 32'(vecs[i].cnt));
            chk($sformatf("r%0d_busy", i), 32'(bus.busy), 32'(vecs[i].busy));
            @(posedge clock);
            #1;
        end

        // Reset landing between accept and response discards the read.
        do_reset();
        drive(2'b11, 4'b0000, 8'h21);
        @(negedge clock);
        chk("mid_ready", 32'(bus.req_ready), 32'h1);
        @(posedge clock);
        #1;
        chk("mid_busy_before", 32'(bus.busy), 32'h1);
        chk("mid_cnt_before", 32'(bus.conflict_count), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        $display("reset mid-read ready=%b en=%b busy=%b cnt=%0d", bus.req_ready, bus.bram_en,
                 bus.busy, bus.conflict_count);
        chk("rst_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_bram_en", 32'(bus.bram_en), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_cnt", 32'(bus.conflict_count), 32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        reset = 1'b0;
        drive(2'b00, 4'b0000, 8'h00);
        for (int k = 0; k < 2; k++) begin
            @(posedge clock);
            #1;
            chk($sformatf("post_rst_rsp_valid%0d", k), 32'(bus.rsp_valid), 32'h0);
            chk($sformatf("post_rst_busy%0d", k), 32'(bus.busy), 32'h0);
        end
        drive(2'b11, 4'b0000, 8'h21);
        @(negedge clock);
        chk("post_rst_ptr_ready", 32'(bus.req_ready), 32'h1);
        @(posedge clock);
        #1;
        drive(2'b00, 4'b0000, 8'h00);

        // Five stalled cycles: the 2-bit counter sticks at 3, the 16-bit one reaches 5.
        do_reset();
        drive(2'b11, 4'b0000, 8'h21);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clock);
            #1;
            $display("stall %0d sat_cnt=%0d cnt=%0d", k, sbus.conflict_count, bus.conflict_count);
            chk($sformatf("sat_cnt%0d", k), 32'(sbus.conflict_count), (k > 3) ? 32'd3 : 32'(k));
            chk($sformatf("wide_cnt%0d", k), 32'(bus.conflict_count), 32'(k));
        end
        drive(2'b00, 4'b0000, 8'h00);
        @(posedge clock);
        #1;
        chk("sat_hold", 32'(sbus.conflict_count), 32'd3);
        chk("wide_hold", 32'(bus.conflict_count), 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
